instr_fetch_unit: RTL and testbench

//  Responder side of the control unit's fetch interface. Owns PC, MAR, fetch buffer and IR.

---
 rtl/instr_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: the responder side of the control unit's fetch interface.
// Owns the program counter, memory address register, a one-word fetch buffer and the
// instruction register. It issues exactly one memory read per accepted fetch request.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that waits TIMEOUT cycles
// without read data. The abort clears IR, raises ready_flag and sets the sticky fetch_err.
// When the macro is undefined, the unit waits for read data indefinitely and fetch_err is 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   pc_en, pc_load    load PC with pc_load (takes priority over pc_inc)
//   pc_inc            increment PC, wrapping at 2^ADDR_W
//   mar_load          copy PC into MAR and start a fetch (accepted only when idle)
//   ir_load           move fetched word into IR
//   mem_rd_en         one-cycle read strobe; mem_addr carries MAR
//   mem_rdata         read data, sampled only while mem_rvalid is high in WAIT
//   mem_rvalid        read data valid
//   command_word      IR contents
//   ready_flag        IR holds the word from the latest completed fetch
//   pc_current_value  PC register
//   fetch_err         sticky timeout flag
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WORD_W  = 24,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic [ADDR_W-1:0] pc_load,
  input  logic              pc_inc,
  input  logic              mar_load,
  input  logic              ir_load,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [WORD_W-1:0] command_word,
  output logic              ready_flag,
  output logic [ADDR_W-1:0] pc_current_value,
  output logic              fetch_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic              ready_q, ready_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            timeout;

  // The counter sits at zero outside WAIT, so it is already clear on WAIT entry.
  assign cnt_d   = (state_q == StWait) ? cnt_q + 1'b1 : '0;
  // True on the TIMEOUT-th edge spent in WAIT.
  assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Load beats increment when both are asserted.
  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      pc_d = pc_load;
    end else if (pc_inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    ir_d      = ir_q;
    ready_d   = ready_q;
    mem_rd_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (mar_load) begin
          mar_d     = pc_q;
          ready_d   = 1'b0;
          buf_vld_d = 1'b0;
          state_d   = StReq;
        end
      end
      StReq: begin
        mem_rd_en = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          if (ir_load) begin
            // Bypass the buffer when the consumer is already waiting.
            ir_d    = mem_rdata;
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            buf_d     = mem_rdata;
            buf_vld_d = 1'b1;
            state_d   = StFull;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          ir_d    = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      StFull: begin
        if (ir_load && buf_vld_q) begin
          ir_d      = buf_q;
          ready_d   = 1'b1;
          buf_vld_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      mar_q     <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      ir_q      <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      ir_q      <= ir_d;
      ready_q   <= ready_d;
    end
  end

  assign mem_addr         = mar_q;
  assign command_word     = ir_q;
  assign ready_flag       = ready_q;
  assign pc_current_value = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A behavioural memory answers each read strobe
// after a programmable latency; expected words and read addresses are queued when a fetch
// is started and compared when the unit delivers them.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_load;
  logic              pc_inc;
  logic              mar_load;
  logic              ir_load;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [WORD_W-1:0] command_word;
  logic              ready_flag;
  logic [ADDR_W-1:0] pc_current_value;
  logic              fetch_err;

  instr_fetch_unit #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_en           (pc_en),
    .pc_load         (pc_load),
    .pc_inc          (pc_inc),
    .mar_load        (mar_load),
    .ir_load         (ir_load),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .command_word    (command_word),
    .ready_flag      (ready_flag),
    .pc_current_value(pc_current_value),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] mem [256];
  logic [WORD_W-1:0] exp_word [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [ADDR_W-1:0] obs_addr [$];
  logic [ADDR_W-1:0] pc_model;

  // Memory model controls (written by the main thread only).
  int mem_lat    = 1;
  bit mem_auto   = 1'b1;
  int stray_req  = 0;
  // Memory model state (written by the memory thread only).
  int stray_done = 0;
  int rd_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder, evaluated 2 time units after each rising edge.
  initial begin
    int               pend_cnt;
    logic [ADDR_W-1:0] pend_addr;
    pend_cnt   = 0;
    pend_addr  = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[pend_addr];
        end
      end
      if (stray_req != stray_done) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 24'hFFFFFF;
        stray_done++;
      end
      if (mem_rd_en === 1'b1) begin
        rd_cnt++;
        obs_addr.push_back(mem_addr);
        if (mem_auto) begin
          pend_addr = mem_addr;
          pend_cnt  = mem_lat;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst      = 1'b0;
    pc_model = '0;
    exp_word.delete();
  endtask

  // Pulse mar_load for one edge; on return the unit is in its read-strobe cycle.
  task automatic start_fetch();
    exp_word.push_back(mem[pc_model]);
    exp_addr.push_back(pc_model);
    mar_load = 1'b1;
    cyc();
    mar_load = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (ready_flag !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic check_word(input string tag);
    logic [WORD_W-1:0] w;
    if (exp_word.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      w = exp_word.pop_front();
      check(tag, 32'(command_word), 32'(w));
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_nreads"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
      check({tag, "_addr"}, 32'(obs_addr.pop_front()), 32'(exp_addr.pop_front()));
    end
    obs_addr.delete();
    exp_addr.delete();
  endtask

  initial begin
    int n;
    int rd0;
    rst = 1'b1; pc_en = 1'b0; pc_load = '0; pc_inc = 1'b0; mar_load = 1'b0; ir_load = 1'b0;
    pc_model = '0;
    for (int i = 0; i < 256; i++) mem[i] = 24'(i * 24'h010101) ^ 24'h5A0000;
    mem[8'h00] = 24'h030102;
    mem[8'h40] = 24'hABCDEF;
    mem[8'h41] = 24'h123456;

    // Reset state
    do_reset();
    check("rst_pc", 32'(pc_current_value), 32'h0);
    check("rst_ready", 32'(ready_flag), 32'h0);
    check("rst_cmd", 32'(command_word), 32'h0);
    check("rst_rd_en", 32'(mem_rd_en), 32'h0);
    check("rst_err", 32'(fetch_err), 32'h0);

    // Basic fetch, latency 1, ir_load held
    mem_lat = 1;
    ir_load = 1'b1;
    start_fetch();
    check("t1_rd_en", 32'(mem_rd_en), 32'h1);
    check("t1_addr", 32'(mem_addr), 32'h0);
    wait_ready(20, n);
    check("t1_latency", 32'(n), 32'd2);
    check_word("t1_word");
    cyc();
    check("t1_rd_en_low", 32'(mem_rd_en), 32'h0);
    check_reads("t1");

    // PC wrap and load-over-increment priority
    ir_load = 1'b0;
    pc_en = 1'b1; pc_load = 8'hFF; cyc(); pc_en = 1'b0;
    check("t2_load_ff", 32'(pc_current_value), 32'hFF);
    pc_inc = 1'b1; cyc(); pc_inc = 1'b0;
    check("t2_wrap", 32'(pc_current_value), 32'h00);
    pc_en = 1'b1; pc_load = 8'h40; pc_inc = 1'b1; cyc(); pc_en = 1'b0; pc_inc = 1'b0;
    check("t2_load_wins", 32'(pc_current_value), 32'h40);
    pc_model = 8'h40;

    // Latency 4, mar_load and a PC change during WAIT
    mem_lat = 4;
    ir_load = 1'b1;
    rd0 = rd_cnt;
    start_fetch();
    cyc();
    mar_load = 1'b1; pc_inc = 1'b1;
    cyc();
    mar_load = 1'b0; pc_inc = 1'b0;
    pc_model = 8'h41;
    wait_ready(20, n);
    check("t3_latency", 32'(n + 2), 32'd5);
    check_word("t3_word");
    check("t3_pc", 32'(pc_current_value), 32'h41);
    repeat (6) cyc();
    check("t3_one_read", 32'(rd_cnt - rd0), 32'd1);
    check("t3_ready_hold", 32'(ready_flag), 32'h1);
    check("t3_cmd_stable", 32'(command_word), 32'hABCDEF);
    check_reads("t3");

    // Data buffered while ir_load is low
    mem_lat = 2;
    ir_load = 1'b0;
    start_fetch();
    check("t4_ready_clr", 32'(ready_flag), 32'h0);
    repeat (6) cyc();
    check("t4_ready_wait", 32'(ready_flag), 32'h0);
    check("t4_ir_kept", 32'(command_word), 32'hABCDEF);
    ir_load = 1'b1;
    cyc();
    check("t4_ready", 32'(ready_flag), 32'h1);
    check_word("t4_word");
    check_reads("t4");

    // Reset during WAIT, then a stray rvalid
    mem_auto = 1'b0;
    start_fetch();
    repeat (3) cyc();
    do_reset();
    mem_auto = 1'b1;
    stray_req++;
    cyc();
    cyc();
    check("t5_ready", 32'(ready_flag), 32'h0);
    check("t5_cmd", 32'(command_word), 32'h0);
    check("t5_rd_en", 32'(mem_rd_en), 32'h0);
    check("t5_pc", 32'(pc_current_value), 32'h0);
    check_reads("t5");
    mem_lat = 3;
    start_fetch();
    wait_ready(20, n);
    check("t5_refetch_lat", 32'(n), 32'd4);
    check_word("t5_refetch");
    check_reads("t5b");

    // No read data at all
    mem_auto = 1'b0;
    start_fetch();
`ifdef FETCH_TIMEOUT_EN
    wait_ready(40, n);
    check("t6_timeout_lat", 32'(n), 32'(TIMEOUT + 1));
    check("t6_err", 32'(fetch_err), 32'h1);
    check("t6_cmd", 32'(command_word), 32'h0);
    check("t6_ready", 32'(ready_flag), 32'h1);
    exp_word.delete();
    mem_auto = 1'b1;
    mem_lat  = 1;
    start_fetch();
    wait_ready(20, n);
    check_word("t6_after");
    check("t6_err_sticky", 32'(fetch_err), 32'h1);
`else
    repeat (30) cyc();
    check("t6_hold_ready", 32'(ready_flag), 32'h0);
    check("t6_no_err", 32'(fetch_err), 32'h0);
    check("t6_no_reread", 32'(mem_rd_en), 32'h0);
    do_reset();
    mem_auto = 1'b1;
`endif
    check_reads("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
